// File: rtl/traffic_pkg.sv
// Shared light encodings, intersection state type and state-to-light decode.
// The PED_WALK state exists only when INTERSECTION_PED_EN is defined.
package traffic_pkg;

   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] YELLOW = 3'b010;
   localparam logic [2:0] GREEN  = 3'b001;
   localparam logic [2:0] OFF    = 3'b000;

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      AR_TO_EW  = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      AR_TO_NS  = 3'd5
`ifdef INTERSECTION_PED_EN
      ,
      PED_WALK  = 3'd6
`endif
   } isect_state_t;

   // Returns {ns_lights, ew_lights}; anything not a green/yellow state is all-red.
   function automatic logic [5:0] state_lights(input isect_state_t s);
      logic [5:0] l;
      case (s)
         NS_GREEN:  l = {GREEN, RED};
         NS_YELLOW: l = {YELLOW, RED};
         EW_GREEN:  l = {RED, GREEN};
         EW_YELLOW: l = {RED, YELLOW};
         default:   l = {RED, RED};
      endcase
      return l;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter: synchronous clear, optional hold at the last count,
// and done flag when count == last (the phase limit minus one).
module phase_timer #(
   parameter int unsigned TW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          sat,
   input  logic [TW-1:0] last,
   output logic [TW-1:0] count,
   output logic          done
);

   assign done = (count == last);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (!(sat && done)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/intersection_ctrl.sv
// Two-approach intersection controller sharing right-of-way between NS and EW.
// Define INTERSECTION_PED_EN to add the pedestrian walk phase (ped_req/walk).
module intersection_ctrl
   import traffic_pkg::*;
#(
   parameter int unsigned GREEN_MIN = 10,
   parameter int unsigned GREEN_MAX = 30,
   parameter int unsigned YELLOW_T  = 4,
   parameter int unsigned ALLRED_T  = 2,
`ifdef INTERSECTION_PED_EN
   parameter int unsigned WALK_T    = 8,
`endif
   parameter int unsigned TW        = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ns_sense,
   input  logic       ew_sense,
`ifdef INTERSECTION_PED_EN
   input  logic       ped_req,
   output logic       walk,
`endif
   output logic [2:0] ns_lights,
   output logic [2:0] ew_lights,
   output logic [2:0] phase
);

   localparam logic [TW-1:0] GMIN_LAST = TW'(GREEN_MIN - 1);
   localparam logic [TW-1:0] GMAX_LAST = TW'(GREEN_MAX - 1);
   localparam logic [TW-1:0] YEL_LAST  = TW'(YELLOW_T - 1);
   localparam logic [TW-1:0] AR_LAST   = TW'(ALLRED_T - 1);
`ifdef INTERSECTION_PED_EN
   localparam logic [TW-1:0] WALK_LAST = TW'(WALK_T - 1);
`endif

   isect_state_t  state_q, state_d;
   logic          ns_req, ew_req;
   logic          ns_dem, ew_dem;
   logic          ped_pend;
   logic [TW-1:0] timer, last;
   logic          done, sat, state_chg;

`ifdef INTERSECTION_PED_EN
   logic ped_q;
   logic walk_to_ew;
   assign ped_pend = ped_q;
`else
   assign ped_pend = 1'b0;
`endif

   // A pending pedestrian counts as opposing demand for either green.
   assign ns_dem = ns_req | ped_pend;
   assign ew_dem = ew_req | ped_pend;

   assign sat       = (state_q == NS_GREEN) || (state_q == EW_GREEN);
   assign state_chg = (state_d != state_q);
   assign phase     = state_q;

   always_comb begin
      case (state_q)
         NS_GREEN, EW_GREEN:  last = GMAX_LAST;
         NS_YELLOW, EW_YELLOW: last = YEL_LAST;
`ifdef INTERSECTION_PED_EN
         PED_WALK:            last = WALK_LAST;
`endif
         default:             last = AR_LAST;
      endcase
   end

   phase_timer #(
      .TW(TW)
   ) u_timer (
      .clk  (clk),
      .reset(reset),
      .clear(state_chg),
      .sat  (sat),
      .last (last),
      .count(timer),
      .done (done)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         NS_GREEN:
            if (ew_dem && (timer >= GMIN_LAST) && (!ns_sense || (timer == GMAX_LAST)))
               state_d = NS_YELLOW;
         NS_YELLOW:
            if (done) state_d = AR_TO_EW;
         AR_TO_EW:
            if (done) state_d = ped_pend ? isect_state_t'(3'd6) : EW_GREEN;
         EW_GREEN:
            if (ns_dem && (timer >= GMIN_LAST) && (!ew_sense || (timer == GMAX_LAST)))
               state_d = EW_YELLOW;
         EW_YELLOW:
            if (done) state_d = AR_TO_NS;
         AR_TO_NS:
            if (done) state_d = ped_pend ? isect_state_t'(3'd6) : NS_GREEN;
`ifdef INTERSECTION_PED_EN
         PED_WALK:
            if (done) state_d = walk_to_ew ? EW_GREEN : NS_GREEN;
`endif
         default:
            state_d = NS_GREEN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= NS_GREEN;
         ns_req    <= 1'b0;
         ew_req    <= 1'b0;
         ns_lights <= GREEN;
         ew_lights <= RED;
`ifdef INTERSECTION_PED_EN
         ped_q      <= 1'b0;
         walk       <= 1'b0;
         walk_to_ew <= 1'b0;
`endif
      end else begin
         state_q                <= state_d;
         {ns_lights, ew_lights} <= state_lights(state_d);
         // Clearing on green entry takes priority over a same-cycle sensor set.
         if (state_d == NS_GREEN && state_q != NS_GREEN) ns_req <= 1'b0;
         else if (ns_sense && state_q != NS_GREEN)       ns_req <= 1'b1;
         if (state_d == EW_GREEN && state_q != EW_GREEN) ew_req <= 1'b0;
         else if (ew_sense && state_q != EW_GREEN)       ew_req <= 1'b1;
`ifdef INTERSECTION_PED_EN
         if (state_d == PED_WALK && state_q != PED_WALK) ped_q <= 1'b0;
         else if (ped_req)                               ped_q <= 1'b1;
         walk <= (state_d == PED_WALK);
         // Remember which green the walk phase displaced.
         if (state_q == AR_TO_EW)      walk_to_ew <= 1'b1;
         else if (state_q == AR_TO_NS) walk_to_ew <= 1'b0;
`endif
      end
   end

endmodule
